wb_csr_ctrl: RTL

Write-back-stage CSR requester and exception committer: the initiator side of the CSR register file's access and trap port. It latches retiring instructions from MEM and drives csrrd/csrwr/csrxchg accesses. It commits exceptions, interrupts and ertn as single-cycle pulses and returns the old CSR value to the GPR file. It redirects fetch to `ex_entry`/`ertn_entry` and kills younger in-flight instructions for a fixed drain window.

---
 rtl/wb_csr_ctrl_pkg.sv | 32 +++
 rtl/wb_csr_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/wb_csr_ctrl_pkg.sv
// Shared encodings and WB-stage bundle for the CSR requester.
// Op codes, ecodes and FSM states used by wb_csr_ctrl.
package wb_csr_ctrl_pkg;

   localparam logic [2:0] WB_OP_NONE    = 3'd0;
   localparam logic [2:0] WB_OP_CSRRD   = 3'd1;
   localparam logic [2:0] WB_OP_CSRWR   = 3'd2;
   localparam logic [2:0] WB_OP_CSRXCHG = 3'd3;
   localparam logic [2:0] WB_OP_ERTN    = 3'd4;
   localparam logic [2:0] WB_OP_SYSCALL = 3'd5;

   localparam logic [5:0] ECODE_INT = 6'h00;
   localparam logic [5:0] ECODE_SYS = 6'h0B;

   localparam logic [0:0] S_RUN   = 1'b0;
   localparam logic [0:0] S_DRAIN = 1'b1;

   typedef struct packed {
      logic [31:0] pc;
      logic [2:0]  op;
      logic [13:0] csr_num;
      logic [4:0]  rd;
      logic [31:0] rd_value;
      logic [31:0] rj_value;
      logic        gpr_we;
      logic [31:0] gpr_wdata;
      logic        ex;
      logic [5:0]  ecode;
      logic [8:0]  esubcode;
   } wb_reg_t;

endpackage

// File: rtl/wb_csr_ctrl.sv
// Write-back CSR requester and exception committer.
// Commits one latched instruction per cycle; flushes open a kill window.
module wb_csr_ctrl
   import wb_csr_ctrl_pkg::*;
#(
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_pc,
   input  logic [2:0]  in_op,
   input  logic [13:0] in_csr_num,
   input  logic [4:0]  in_rd,
   input  logic [31:0] in_rd_value,
   input  logic [31:0] in_rj_value,
   input  logic        in_gpr_we,
   input  logic [31:0] in_gpr_wdata,
   input  logic        in_ex,
   input  logic [5:0]  in_ecode,
   input  logic [8:0]  in_esubcode,
   output logic        csr_re,
   output logic [13:0] csr_num,
   output logic        csr_we,
   output logic [31:0] csr_wmask,
   output logic [31:0] csr_wvalue,
   input  logic [31:0] csr_rvalue,
   output logic        wb_ex,
   output logic [5:0]  wb_ecode,
   output logic [8:0]  wb_esubcode,
   output logic [31:0] wb_pc,
   output logic        ertn_flush,
   input  logic [31:0] ex_entry,
   input  logic [31:0] ertn_entry,
   input  logic        has_int,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        flush,
   output logic [31:0] flush_target
);

   localparam logic [3:0] CNT_INIT = 4'(DRAIN_CYCLES - 1);

   wb_reg_t     wb;
   logic        wb_valid;
   logic [0:0]  state;
   logic [3:0]  cnt;
   logic        act;
   logic        is_csr;
   logic        rest;
   logic        k_int;
   logic        k_ex;
   logic        k_sys;
   logic        k_ertn;
   logic        k_csr;
   logic        k_plain;

   assign in_ready = ~reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         wb_valid <= 1'b0;
         wb       <= '0;
      end else begin
         wb_valid <= in_valid & in_ready;
         if (in_valid & in_ready)
            wb <= '{in_pc, in_op, in_csr_num, in_rd,
                    in_rd_value, in_rj_value, in_gpr_we,
                    in_gpr_wdata, in_ex, in_ecode,
                    in_esubcode};
      end
   end

   // Anything latched while draining is a younger, killed instruction.
   assign act    = ~reset & wb_valid & (state == S_RUN);
   assign is_csr = (wb.op == WB_OP_CSRRD) |
                   (wb.op == WB_OP_CSRWR) |
                   (wb.op == WB_OP_CSRXCHG);

   assign k_int   = act & has_int;
   assign k_ex    = act & ~has_int & wb.ex;
   assign rest    = act & ~has_int & ~wb.ex;
   assign k_sys   = rest & (wb.op == WB_OP_SYSCALL);
   assign k_ertn  = rest & (wb.op == WB_OP_ERTN);
   assign k_csr   = rest & is_csr;
   assign k_plain = rest & ~is_csr &
                    (wb.op != WB_OP_SYSCALL) &
                    (wb.op != WB_OP_ERTN);

   always_comb begin
      csr_re       = 1'b0;
      csr_num      = '0;
      csr_we       = 1'b0;
      csr_wmask    = '0;
      csr_wvalue   = '0;
      wb_ex        = 1'b0;
      wb_ecode     = '0;
      wb_esubcode  = '0;
      wb_pc        = '0;
      ertn_flush   = 1'b0;
      rf_we        = 1'b0;
      rf_waddr     = '0;
      rf_wdata     = '0;
      flush        = 1'b0;
      flush_target = '0;
      unique case (1'b1)
         k_int: begin
            wb_ex        = 1'b1;
            wb_ecode     = ECODE_INT;
            wb_pc        = wb.pc;
            flush        = 1'b1;
            flush_target = ex_entry;
         end
         k_ex: begin
            wb_ex        = 1'b1;
            wb_ecode     = wb.ecode;
            wb_esubcode  = wb.esubcode;
            wb_pc        = wb.pc;
            flush        = 1'b1;
            flush_target = ex_entry;
         end
         k_sys: begin
            wb_ex        = 1'b1;
            wb_ecode     = ECODE_SYS;
            wb_pc        = wb.pc;
            flush        = 1'b1;
            flush_target = ex_entry;
         end
         k_ertn: begin
            ertn_flush   = 1'b1;
            flush        = 1'b1;
            flush_target = ertn_entry;
         end
         k_csr: begin
            csr_re   = 1'b1;
            csr_num  = wb.csr_num;
            rf_we    = wb.rd != 5'd0;
            rf_waddr = wb.rd;
            rf_wdata = csr_rvalue;
            if (wb.op != WB_OP_CSRRD) begin
               csr_we     = 1'b1;
               csr_wvalue = wb.rd_value;
               csr_wmask  = (wb.op == WB_OP_CSRWR) ?
                            32'hFFFF_FFFF : wb.rj_value;
            end
         end
         k_plain: begin
            rf_we    = wb.gpr_we;
            rf_waddr = wb.rd;
            rf_wdata = wb.gpr_wdata;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_RUN;
         cnt   <= '0;
      end else begin
         case (state)
            S_RUN: begin
               if (flush) begin
                  state <= S_DRAIN;
                  cnt   <= CNT_INIT;
               end
            end
            default: begin
               if (cnt == 4'd0)
                  state <= S_RUN;
               else
                  cnt <= cnt - 4'd1;
            end
         endcase
      end
   end

endmodule
